irom_arbiter: RTL and testbench

//   Shares the single-port instruction ROM bus (HADDR/HWDATA/HWRITE/HRDATA)

---
 rtl/irom_arbiter.sv | 141 ++++++++++++++
 tb/tb_irom_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irom_arbiter.sv
// Shares the single-port instruction ROM bus between the fetch (IF) and load/store (MEM) stages.
// Define IROM_ARB_RR_EN for round-robin; default is MEM priority with an IF starvation guard.
module irom_arbiter #(
   parameter int unsigned ADDR_W       = 64,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned ROM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              mem_req,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_write,
   output logic              mem_gnt,
   output logic              mem_rvalid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] HADDR,
   output logic [DATA_W-1:0] HWDATA,
   output logic              HWRITE,
   input  logic [DATA_W-1:0] HRDATA,
   output logic              busy
);

   localparam int unsigned LatW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e            r_state, w_state_d;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_write;
   logic              r_owner_mem;
   logic [LatW-1:0]   r_lat;
   logic              w_arb;
   logic              w_pick_mem;
   logic              w_gnt_if;
   logic              w_gnt_mem;

   // Grants are gated by reset so nothing is accepted while the block is held in reset.
   assign w_arb     = ((r_state == StIdle) || (r_state == StResp)) && !HRESET;
   assign w_gnt_mem = w_arb && w_pick_mem;
   assign w_gnt_if  = w_arb && if_req && !w_pick_mem;

`ifdef IROM_ARB_RR_EN
   logic r_prio_mem;

   assign w_pick_mem = mem_req && (!if_req || r_prio_mem);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_prio_mem <= 1'b0;
      end else if (w_gnt_if) begin
         r_prio_mem <= 1'b1;
      end else if (w_gnt_mem) begin
         r_prio_mem <= 1'b0;
      end
   end
`else
   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

   logic [StarveW-1:0] r_starve;
   logic               w_starved;

   assign w_starved  = (r_starve == StarveW'(STARVE_LIMIT));
   assign w_pick_mem = mem_req && !(if_req && w_starved);

   // Counts consecutive arbitrations IF lost while still requesting.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_starve <= '0;
      end else if (!if_req || w_gnt_if) begin
         r_starve <= '0;
      end else if (w_gnt_mem && !w_starved) begin
         r_starve <= r_starve + 1'b1;
      end
   end
`endif

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:  if (w_gnt_if || w_gnt_mem) w_state_d = StIssue;
         StIssue: if (r_lat == '0) w_state_d = StResp;
         StResp:  w_state_d = (w_gnt_if || w_gnt_mem) ? StIssue : StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state     <= StIdle;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_write     <= 1'b0;
         r_owner_mem <= 1'b0;
         r_lat       <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_gnt_mem) begin
            r_addr      <= mem_addr;
            r_wdata     <= mem_wdata;
            r_write     <= mem_write;
            r_owner_mem <= 1'b1;
            r_lat       <= LatW'(ROM_LATENCY - 1);
         end else if (w_gnt_if) begin
            r_addr      <= if_addr;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_owner_mem <= 1'b0;
            r_lat       <= LatW'(ROM_LATENCY - 1);
         end else if (r_state == StIssue) begin
            if (r_lat != '0) begin
               r_lat <= r_lat - 1'b1;
            end else begin
               r_rdata <= r_write ? '0 : HRDATA;
            end
         end
      end
   end

   // HADDR/HWDATA simply hold the last latched request outside ISSUE.
   assign HADDR      = r_addr;
   assign HWDATA     = r_wdata;
   assign HWRITE     = (r_state == StIssue) && r_write;
   assign busy       = (r_state != StIdle);
   assign if_gnt     = w_gnt_if;
   assign mem_gnt    = w_gnt_mem;
   assign if_rvalid  = (r_state == StResp) && !r_owner_mem;
   assign mem_rvalid = (r_state == StResp) && r_owner_mem;
   assign if_rdata   = if_rvalid ? r_rdata : '0;
   assign mem_rdata  = mem_rvalid ? r_rdata : '0;

endmodule

// File: tb/tb_irom_arbiter.sv
// Directed bench for irom_arbiter: one L=1 instance (a_*) and one L=3 instance (b_*) sharing a
// small word-addressed ROM model.
module tb_irom_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic rom_load;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   logic        a_if_req, a_if_gnt, a_if_rvalid, a_mem_req, a_mem_write, a_mem_gnt, a_mem_rvalid;
   logic        a_hwrite, a_busy;
   logic [63:0] a_if_addr, a_if_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [63:0] a_haddr, a_hwdata, a_hrdata;
   logic        b_if_req, b_if_gnt, b_if_rvalid, b_mem_req, b_mem_write, b_mem_gnt, b_mem_rvalid;
   logic        b_hwrite, b_busy;
   logic [63:0] b_if_addr, b_if_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [63:0] b_haddr, b_hwdata, b_hrdata;

   logic [31:0]  rom [0:63];
   logic [261:0] a_all;

   assign a_hrdata = {32'h0, rom[a_haddr[7:2]]};
   assign b_hrdata = {32'h0, rom[b_haddr[7:2]]};
   assign a_all = {a_if_gnt, a_if_rvalid, a_if_rdata, a_mem_gnt, a_mem_rvalid, a_mem_rdata,
                   a_haddr, a_hwdata, a_hwrite, a_busy};

   always @(posedge clk) begin
      if (rom_load) begin
         for (int i = 0; i < 64; i++) rom[i] <= 32'h0;
         rom[0] <= 32'h0000_0093;
         rom[1] <= 32'h0010_8093;
         rom[2] <= 32'h0020_8113;
      end else begin
         if (a_hwrite) rom[a_haddr[7:2]] <= a_hwdata[31:0];
         if (b_hwrite) rom[b_haddr[7:2]] <= b_hwdata[31:0];
      end
   end

   irom_arbiter #(.ADDR_W(64), .DATA_W(64), .ROM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
      .HCLK(clk), .HRESET(rst),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
      .if_rdata(a_if_rdata), .mem_req(a_mem_req), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_write(a_mem_write), .mem_gnt(a_mem_gnt),
      .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata), .HADDR(a_haddr),
      .HWDATA(a_hwdata), .HWRITE(a_hwrite), .HRDATA(a_hrdata), .busy(a_busy)
   );

   irom_arbiter #(.ADDR_W(64), .DATA_W(64), .ROM_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
      .HCLK(clk), .HRESET(rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
      .if_rdata(b_if_rdata), .mem_req(b_mem_req), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_write(b_mem_write), .mem_gnt(b_mem_gnt),
      .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata), .HADDR(b_haddr),
      .HWDATA(b_hwdata), .HWRITE(b_hwrite), .HRDATA(b_hrdata), .busy(b_busy)
   );

   task automatic test_reset();
      rst = 1'b1; rom_load = 1'b1;
      a_if_req = 0; a_if_addr = '0; a_mem_req = 0; a_mem_addr = '0; a_mem_wdata = '0;
      a_mem_write = 0;
      b_if_req = 0; b_if_addr = '0; b_mem_req = 0; b_mem_addr = '0; b_mem_wdata = '0;
      b_mem_write = 0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (a_all !== '0) begin
         n_fail++; $display("FAIL reset_outputs_a got=%h exp=0", a_all);
      end
      n_checks++;
      if ({b_if_gnt, b_mem_gnt, b_if_rvalid, b_mem_rvalid, b_hwrite, b_busy, b_haddr} !== '0) begin
         n_fail++; $display("FAIL reset_outputs_b busy=%b haddr=%h exp 0", b_busy, b_haddr);
      end
      @(negedge clk);
      rst = 1'b0; rom_load = 1'b0;
   endtask

   task automatic test_if_fetch();
      @(negedge clk);
      a_if_req = 1; a_if_addr = 64'h4;
      #1;
      n_checks++;
      if ({a_if_gnt, a_mem_gnt} !== 2'b10) begin
         n_fail++; $display("FAIL fetch_gnt got=%b exp=10", {a_if_gnt, a_mem_gnt});
      end
      @(negedge clk);
      a_if_req = 0; a_if_addr = 64'hFFF0;
      #1;
      n_checks++;
      if ({a_haddr, a_busy, a_if_rvalid} !== {64'h4, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL fetch_issue haddr=%h busy=%b rv=%b exp 4/1/0",
                            a_haddr, a_busy, a_if_rvalid);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({a_if_rvalid, a_if_rdata} !== {1'b1, 64'h0010_8093}) begin
         n_fail++; $display("FAIL fetch_resp rv=%b rdata=%h exp 1/00108093",
                            a_if_rvalid, a_if_rdata);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({a_if_rvalid, a_busy} !== 2'b00) begin
         n_fail++; $display("FAIL fetch_idle rv=%b busy=%b exp 0/0", a_if_rvalid, a_busy);
      end
   endtask

   task automatic test_mem_write_read();
      @(negedge clk);
      a_mem_req = 1; a_mem_write = 1; a_mem_addr = 64'h20; a_mem_wdata = 64'hDEAD_BEEF;
      #1;
      n_checks++;
      if ({a_mem_gnt, a_if_gnt, a_hwrite} !== 3'b100) begin
         n_fail++; $display("FAIL wr_gnt got=%b exp=100", {a_mem_gnt, a_if_gnt, a_hwrite});
      end
      @(negedge clk);
      a_mem_req = 0; a_mem_write = 0;
      #1;
      n_checks++;
      if ({a_hwrite, a_haddr, a_hwdata} !== {1'b1, 64'h20, 64'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL wr_issue hwrite=%b haddr=%h hwdata=%h exp 1/20/deadbeef",
                            a_hwrite, a_haddr, a_hwdata);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({a_hwrite, a_mem_rvalid, a_mem_rdata} !== {1'b0, 1'b1, 64'h0}) begin
         n_fail++; $display("FAIL wr_resp hwrite=%b rv=%b rdata=%h exp 0/1/0",
                            a_hwrite, a_mem_rvalid, a_mem_rdata);
      end
      @(negedge clk);
      a_mem_req = 1; a_mem_addr = 64'h20;
      #1;
      n_checks++;
      if ({a_mem_gnt, a_hwrite} !== 2'b10) begin
         n_fail++; $display("FAIL rd_gnt got=%b exp=10", {a_mem_gnt, a_hwrite});
      end
      @(negedge clk);
      a_mem_req = 0;
      #1;
      n_checks++;
      if (a_hwrite !== 1'b0) begin
         n_fail++; $display("FAIL rd_issue_hwrite got=%b exp=0", a_hwrite);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({a_mem_rvalid, a_mem_rdata} !== {1'b1, 64'h0000_0000_DEAD_BEEF}) begin
         n_fail++; $display("FAIL rd_resp rv=%b rdata=%h exp 1/00000000deadbeef",
                            a_mem_rvalid, a_mem_rdata);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (a_mem_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL rd_done rv=%b exp=0", a_mem_rvalid);
      end
   endtask

   task automatic test_reset_mid_issue();
      @(negedge clk);
      a_if_req = 1; a_if_addr = 64'h8;
      #1;
      n_checks++;
      if (a_if_gnt !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_gnt got=%b exp=1", a_if_gnt);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (a_busy !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_busy got=%b exp=1", a_busy);
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (a_all !== '0) begin
         n_fail++; $display("FAIL rst_mid_outputs got=%h exp=0", a_all);
      end
      @(negedge clk);
      rst = 1'b0; a_if_req = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if ({a_if_rvalid, a_mem_rvalid, a_busy} !== 3'b000) begin
            n_fail++; $display("FAIL rst_after_%0d rv=%b/%b busy=%b exp 0",
                               k, a_if_rvalid, a_mem_rvalid, a_busy);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_arbitration();
      int  got;
      int  both;
      logic order [0:9];
      logic exp_mem;
      got = 0; both = 0;
      for (int i = 0; i < 10; i++) order[i] = 1'bx;
      a_if_req = 1; a_if_addr = 64'h0; a_mem_req = 1; a_mem_write = 0; a_mem_addr = 64'h8;
      for (int c = 0; c < 200 && got < 10; c++) begin
         #1;
         if (a_if_gnt && a_mem_gnt) both++;
         if (a_mem_gnt) begin
            order[got] = 1'b1; got++;
         end else if (a_if_gnt) begin
            order[got] = 1'b0; got++;
         end
         @(negedge clk);
      end
      a_if_req = 0; a_mem_req = 0;
      n_checks++;
      if (got !== 10) begin
         n_fail++; $display("FAIL arb_grant_count got=%0d exp=10", got);
      end
      n_checks++;
      if (both !== 0) begin
         n_fail++; $display("FAIL arb_double_gnt got=%0d exp=0", both);
      end
      for (int i = 0; i < 10; i++) begin
`ifdef IROM_ARB_RR_EN
         exp_mem = (i % 2) == 1;
`else
         exp_mem = (i % 5) != 4;
`endif
         n_checks++;
         if (order[i] !== exp_mem) begin
            n_fail++; $display("FAIL arb_order_%0d got_mem=%b exp_mem=%b", i, order[i], exp_mem);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [130:0] exp_v;
      logic [130:0] got_v;
      @(negedge clk);
      b_mem_req = 1; b_mem_write = 0; b_mem_addr = 64'h0;
      #1;
      n_checks++;
      if (b_mem_gnt !== 1'b1) begin
         n_fail++; $display("FAIL b2b_gnt0 got=%b exp=1", b_mem_gnt);
      end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) b_mem_addr = 64'h8;
         if (k == 5) b_mem_req = 0;
         #1;
         // {gnt, rvalid, busy, haddr, rdata}
         exp_v = {(k == 4), (k == 4 || k == 8), 1'b1, (k <= 4) ? 64'h0 : 64'h8,
                  (k == 4) ? 64'h93 : (k == 8) ? 64'h0020_8113 : 64'h0};
         got_v = {b_mem_gnt, b_mem_rvalid, b_busy, b_haddr, b_mem_rdata};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++; $display("FAIL b2b_cycle_%0d got=%h exp=%h", k, got_v, exp_v);
         end
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({b_mem_rvalid, b_busy} !== 2'b00) begin
         n_fail++; $display("FAIL b2b_idle rv=%b busy=%b exp 0/0", b_mem_rvalid, b_busy);
      end
   endtask

   initial begin
      test_reset();
      test_if_fetch();
      test_mem_write_read();
      test_reset_mid_issue();
      test_arbitration();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
